// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the RV32I core.
// Drives IF/ID/EX stall, flush and bubble controls for load-use hazards,
// taken-branch flushes, data-memory waits with timeout, and sticky halt.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating performance counters
// (Stall_cnt, Flush_cnt, Wait_cnt).
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RUN      | normal flow; resolves trap, memory stall, branch flush, load-use
// MEM_WAIT | data access outstanding; pipeline frozen, branch flush deferred
// HALT     | trap or memory timeout; everything held until Reset_n
module hazard_ctrl #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT        = 255,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          ID_valid,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr,
    input  logic                          ID_uses_rs1,
    input  logic                          ID_uses_rs2,
    input  logic                          EX_valid,
    input  logic                          EX_MemToReg,
    input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr,
    input  logic                          EX_Branch_taken,
    input  logic                          Mem_req,
    input  logic                          Mem_ready,
    input  logic                          trap,
    output logic                          IF_Stall,
    output logic                          ID_Stall,
    output logic                          ID_Flush,
    output logic                          EX_Flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0]          Stall_cnt,
    output logic [CNT_WIDTH-1:0]          Flush_cnt,
    output logic [CNT_WIDTH-1:0]          Wait_cnt,
`endif
    output logic                          Halted,
    output logic                          Mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // 16 bits covers the full legal MEM_TIMEOUT range
    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        pending_q, pending_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic        mem_stall_req;
    logic        flush_req;
    logic        load_use;

    assign mem_stall_req = Mem_req & ~Mem_ready;
    // a deferred flush from a memory wait is applied like a fresh taken branch
    assign flush_req     = pending_q | (EX_Branch_taken & EX_valid);
    // x0 is hard-wired zero, so a load targeting it can never feed a consumer
    assign load_use      = EX_valid & EX_MemToReg & (EX_Rd_addr != '0) & ID_valid &
                           ((ID_uses_rs1 & (ID_Rs1_addr == EX_Rd_addr)) |
                            (ID_uses_rs2 & (ID_Rs2_addr == EX_Rd_addr)));

    assign Halted      = (state_q == HALT);
    assign Mem_timeout = mem_timeout_q;

    // State, wait counter, deferred flush and timeout cause registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= RUN;
            wait_q        <= '0;
            pending_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            pending_q     <= pending_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state and combinational control outputs, in priority order
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pending_d     = pending_q;
        mem_timeout_d = mem_timeout_q;
        IF_Stall      = 1'b0;
        ID_Stall      = 1'b0;
        ID_Flush      = 1'b0;
        EX_Flush      = 1'b0;
        case (state_q)
            RUN: begin
                if (trap) begin
                    IF_Stall = 1'b1;
                    ID_Stall = 1'b1;
                    ID_Flush = 1'b1;
                    EX_Flush = 1'b1;
                    state_d  = HALT;
                end else if (mem_stall_req) begin
                    IF_Stall = 1'b1;
                    ID_Stall = 1'b1;
                    wait_d   = 16'd1;
                    state_d  = MEM_WAIT;
                end else if (flush_req) begin
                    ID_Flush  = 1'b1;
                    EX_Flush  = 1'b1;
                    pending_d = 1'b0;
                end else if (load_use) begin
                    IF_Stall = 1'b1;
                    ID_Stall = 1'b1;
                    EX_Flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                IF_Stall = 1'b1;
                ID_Stall = 1'b1;
                if (EX_Branch_taken) begin
                    pending_d = 1'b1;
                end
                if (trap) begin
                    state_d = HALT;
                end else if (Mem_ready) begin
                    state_d = RUN;
                end else if (wait_q >= TIMEOUT_VAL) begin
                    state_d       = HALT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            HALT: begin
                IF_Stall = 1'b1;
                ID_Stall = 1'b1;
                ID_Flush = 1'b1;
                EX_Flush = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic run_free;
    logic lu_applied;
    logic fl_applied;

    assign run_free   = (state_q == RUN) & ~trap & ~mem_stall_req;
    assign fl_applied = run_free & flush_req;
    assign lu_applied = run_free & ~flush_req & load_use;

    // Saturating event counters; none of the events can occur in HALT
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Stall_cnt <= '0;
            Flush_cnt <= '0;
            Wait_cnt  <= '0;
        end else begin
            if (lu_applied && (Stall_cnt != '1)) begin
                Stall_cnt <= Stall_cnt + 1'b1;
            end
            if (fl_applied && (Flush_cnt != '1)) begin
                Flush_cnt <= Flush_cnt + 1'b1;
            end
            if ((state_q == MEM_WAIT) && (Wait_cnt != '1)) begin
                Wait_cnt <= Wait_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: table-driven RUN-state vectors plus hand-written
// multi-cycle sequences (memory wait, timeout, trap, asynchronous reset).
module tb_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses1;
    logic       uses2;
    logic       ex_valid;
    logic       m2r;
    logic [4:0] rd;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic       trap;

    logic if_a, ids_a, idf_a, exf_a, halt_a, mto_a;
    logic if_b, ids_b, idf_b, exf_b, halt_b, mto_b;
    logic [5:0] out_a;
    logic [5:0] out_b;
    assign out_a = {if_a, ids_a, idf_a, exf_a, halt_a, mto_a};
    assign out_b = {if_b, ids_b, idf_b, exf_b, halt_b, mto_b};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_a, flush_cnt_a, wait_cnt_a;
    logic [31:0] stall_cnt_b, flush_cnt_b, wait_cnt_b;
`endif

    int passed;
    int total;

    hazard_ctrl #(.REGFILE_ADDR_WIDTH(5), .MEM_TIMEOUT(8), .CNT_WIDTH(32)) dut_a (
        .Clk(clk), .Reset_n(reset_n), .ID_valid(id_valid),
        .ID_Rs1_addr(rs1), .ID_Rs2_addr(rs2), .ID_uses_rs1(uses1), .ID_uses_rs2(uses2),
        .EX_valid(ex_valid), .EX_MemToReg(m2r), .EX_Rd_addr(rd), .EX_Branch_taken(br),
        .Mem_req(mreq), .Mem_ready(mrdy), .trap(trap),
        .IF_Stall(if_a), .ID_Stall(ids_a), .ID_Flush(idf_a), .EX_Flush(exf_a),
`ifdef HAZARD_PERF_CNT_EN
        .Stall_cnt(stall_cnt_a), .Flush_cnt(flush_cnt_a), .Wait_cnt(wait_cnt_a),
`endif
        .Halted(halt_a), .Mem_timeout(mto_a)
    );

    hazard_ctrl #(.REGFILE_ADDR_WIDTH(5), .MEM_TIMEOUT(255), .CNT_WIDTH(32)) dut_b (
        .Clk(clk), .Reset_n(reset_n), .ID_valid(id_valid),
        .ID_Rs1_addr(rs1), .ID_Rs2_addr(rs2), .ID_uses_rs1(uses1), .ID_uses_rs2(uses2),
        .EX_valid(ex_valid), .EX_MemToReg(m2r), .EX_Rd_addr(rd), .EX_Branch_taken(br),
        .Mem_req(mreq), .Mem_ready(mrdy), .trap(trap),
        .IF_Stall(if_b), .ID_Stall(ids_b), .ID_Flush(idf_b), .EX_Flush(exf_b),
`ifdef HAZARD_PERF_CNT_EN
        .Stall_cnt(stall_cnt_b), .Flush_cnt(flush_cnt_b), .Wait_cnt(wait_cnt_b),
`endif
        .Halted(halt_b), .Mem_timeout(mto_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses1;
        logic       uses2;
        logic       ex_valid;
        logic       m2r;
        logic [4:0] rd;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic [3:0] exp;   // {IF_Stall, ID_Stall, ID_Flush, EX_Flush}
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b (IF,IDs,IDf,EXf,Halt,Mto)", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; rs1 = 0; rs2 = 0; uses1 = 0; uses2 = 0;
        ex_valid = 0; m2r = 0; rd = 0; br = 0; mreq = 0; mrdy = 0; trap = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        #3;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        //        name          idv rs1 rs2 u1 u2 exv m2r rd  br mq mr exp
        vecs[0]  = '{"idle",      0, 0,  0,  0, 0, 0,  0,  0,  0, 0, 0, 4'b0000};
        vecs[1]  = '{"lu_rs2_x5", 1, 1,  5,  1, 1, 1,  1,  5,  0, 0, 0, 4'b1101};
        vecs[2]  = '{"lu_rd_x0",  1, 0,  0,  1, 1, 1,  1,  0,  0, 0, 0, 4'b0000};
        vecs[3]  = '{"rs1_unused",1, 5,  2,  0, 1, 1,  1,  5,  0, 0, 0, 4'b0000};
        vecs[4]  = '{"lu_rs1_x5", 1, 5,  2,  1, 0, 1,  1,  5,  0, 0, 0, 4'b1101};
        vecs[5]  = '{"ex_invalid",1, 5,  5,  1, 1, 0,  1,  5,  0, 0, 0, 4'b0000};
        vecs[6]  = '{"not_load",  1, 5,  5,  1, 1, 1,  0,  5,  0, 0, 0, 4'b0000};
        vecs[7]  = '{"id_invalid",0, 5,  5,  1, 1, 1,  1,  5,  0, 0, 0, 4'b0000};
        vecs[8]  = '{"br_and_lu", 1, 1,  5,  1, 1, 1,  1,  5,  1, 0, 0, 4'b0011};
        vecs[9]  = '{"br_no_exv", 0, 0,  0,  0, 0, 0,  0,  0,  1, 0, 0, 4'b0000};
        vecs[10] = '{"mem_hit",   0, 0,  0,  0, 0, 0,  0,  0,  0, 1, 1, 4'b0000};
        vecs[11] = '{"br_alone",  0, 0,  0,  0, 0, 1,  0,  0,  1, 0, 0, 4'b0011};

        reset_n = 1'b1;
        clear_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_outputs", out_a, 6'b000000);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // RUN-state combinational responses; none of these leave RUN
        for (int i = 0; i < 12; i++) begin
            id_valid = vecs[i].id_valid; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            uses1 = vecs[i].uses1; uses2 = vecs[i].uses2; ex_valid = vecs[i].ex_valid;
            m2r = vecs[i].m2r; rd = vecs[i].rd; br = vecs[i].br;
            mreq = vecs[i].mreq; mrdy = vecs[i].mrdy; trap = 1'b0;
            #1;
            check(vecs[i].name, out_a, {vecs[i].exp, 2'b00});
            tick();
        end

        // load-use stall does not repeat once the load moves on
        clear_inputs();
        id_valid = 1; rs2 = 5; uses2 = 1; ex_valid = 1; m2r = 1; rd = 5;
        #1;
        check("lu_first", out_a, 6'b110100);
        tick();
        m2r = 0; rd = 7;
        #1;
        check("lu_next", out_a, 6'b000000);
        tick();

`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", {5'b0, stall_cnt_a == 32'd3}, 6'b000001);
        check("flush_cnt_tbl", {5'b0, flush_cnt_a == 32'd2}, 6'b000001);
`endif

        // memory wait, ready in wait cycle 4, branch pulsed in wait cycle 2
        clear_inputs();
        mreq = 1;
        #1;
        check("mw_enter", out_a, 6'b110000);
        tick();
        for (int w = 1; w <= 4; w++) begin
            br = (w == 2); ex_valid = (w == 2);
            mrdy = (w == 4);
            #1;
            check($sformatf("mw_wait%0d", w), out_a, 6'b110000);
            tick();
        end
        clear_inputs();
        #1;
        check("mw_pending_flush", out_a, 6'b001100);
        tick();
        check("mw_after_flush", out_a, 6'b000000);
`ifdef HAZARD_PERF_CNT_EN
        check("flush_cnt_pend", {5'b0, flush_cnt_a == 32'd3}, 6'b000001);
        check("wait_cnt_mw", {5'b0, wait_cnt_a == 32'd4}, 6'b000001);
`endif

        // memory timeout with MEM_TIMEOUT=8
        do_reset();
        mreq = 1;
        #1;
        check("to_enter", out_a, 6'b110000);
        tick();
        for (int w = 1; w <= 8; w++) begin
            if (w == 1 || w == 8)
                check($sformatf("to_wait%0d", w), out_a, 6'b110000);
            tick();
        end
        check("to_halted", out_a, 6'b111111);
        mreq = 0; mrdy = 1; br = 1; ex_valid = 1;
        tick();
        tick();
        check("to_sticky", out_a, 6'b111111);
`ifdef HAZARD_PERF_CNT_EN
        check("wait_cnt_to", {5'b0, wait_cnt_a == 32'd8}, 6'b000001);
`endif

        // reset mid-wait (dut_b at count 10) and mid-halt (dut_a)
        do_reset();
        mreq = 1;
        tick();
        for (int w = 1; w < 10; w++) tick();
        check("b_wait10", out_b, 6'b110000);
        check("a_halted_pre", out_a, 6'b111111);
        #2;
        reset_n = 1'b0;
        clear_inputs();
        #1;
        check("b_async_reset", out_b, 6'b000000);
        check("a_async_reset", out_a, 6'b000000);
        reset_n = 1'b1;
        tick();
        check("b_run_after_rst", out_b, 6'b000000);

        // trap pulse in RUN
        trap = 1;
        #1;
        check("trap_same", out_a, 6'b111100);
        tick();
        trap = 0;
        #1;
        check("trap_halted", out_a, 6'b111110);
        mreq = 1; mrdy = 1; br = 1; ex_valid = 1;
        tick();
        tick();
        check("trap_sticky", out_a, 6'b111110);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the RV32I core. Watches the ID, EX and MEM stages and drives the stall, flush and bubble controls for IF/ID/EX. Handles load-use hazards, taken-branch/jump flushes, multi-cycle data-memory waits with a timeout, and sticky halt on trap. Sits beside ID_top; its ID_Stall/ID_Flush outputs feed the ID stage directly.

Parameters:
REGFILE_ADDR_WIDTH, 5, register address width
MEM_TIMEOUT, 255, max wait cycles for Mem_ready before timeout halt (1..2^16-1)
CNT_WIDTH, 32, width of performance counters (optional feature only)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
ID_valid  in  1  ID stage holds a valid instruction
ID_Rs1_addr  in  REGFILE_ADDR_WIDTH  rs1 of instruction in ID
ID_Rs2_addr  in  REGFILE_ADDR_WIDTH  rs2 of instruction in ID
ID_uses_rs1  in  1  instruction in ID reads rs1
ID_uses_rs2  in  1  instruction in ID reads rs2
EX_valid  in  1  EX stage holds a valid instruction
EX_MemToReg  in  1  EX instruction is a load
EX_Rd_addr  in  REGFILE_ADDR_WIDTH  rd of EX instruction
EX_Branch_taken  in  1  EX resolved a taken branch or jump
Mem_req  in  1  MEM stage has an outstanding data access
Mem_ready  in  1  data memory completes the access this cycle
trap  in  1  trap raised by decode
IF_Stall  out  1  hold PC and IF/ID register
ID_Stall  out  1  hold ID/EX inputs
ID_Flush  out  1  clear IF/ID register to NOP
EX_Flush  out  1  insert bubble into ID/EX register
Halted  out  1  core halted (trap or memory timeout)
Mem_timeout  out  1  halt cause was memory timeout

Behaviour:
- States: RUN, MEM_WAIT, HALT. Registered state. Outputs are combinational from state plus current inputs.
- Reset: asynchronous. State=RUN, pending_flush=0, timeout counter=0, Mem_timeout=0. With no inputs asserted, all outputs are 0.
- Priority, highest first: HALT > MEM_WAIT > branch flush > load-use.
- RUN:
  - trap=1 -> next HALT. Same cycle: IF_Stall=ID_Stall=ID_Flush=EX_Flush=1.
  - Mem_req=1 and Mem_ready=0 -> next MEM_WAIT. Same cycle: IF_Stall=ID_Stall=1, EX_Flush=0, counter cleared to 1.
  - EX_Branch_taken=1 (and EX_valid) -> ID_Flush=1 and EX_Flush=1 for exactly 1 cycle; no stall.
  - Load-use hazard: EX_valid & EX_MemToReg & EX_Rd_addr!=0 & ID_valid & ((ID_uses_rs1 & ID_Rs1_addr==EX_Rd_addr) | (ID_uses_rs2 & ID_Rs2_addr==EX_Rd_addr)).
    - Response: IF_Stall=ID_Stall=1 and EX_Flush=1 for 1 cycle.
    - The next cycle re-evaluates; the load has moved on, so no repeat.
  - Branch and load-use in the same cycle: the branch wins; no stall.
- MEM_WAIT:
  - IF_Stall=ID_Stall=1, no flushes. The counter increments each cycle.
  - EX_Branch_taken=1 seen while in MEM_WAIT sets pending_flush.
  - Mem_ready=1 -> next RUN. In the release cycle, stalls stay asserted. The following RUN cycle applies ID_Flush=EX_Flush=1 if pending_flush, then clears it.
  - Counter reaching MEM_TIMEOUT with Mem_ready=0 -> next HALT and Mem_timeout<=1.
  - Mem_ready and the timeout in the same cycle: Mem_ready wins.
  - trap in MEM_WAIT -> HALT.
- HALT: sticky until Reset_n=0. IF_Stall=ID_Stall=ID_Flush=EX_Flush=Halted=1. Input changes are ignored.
- Reset asserted mid-wait or mid-halt returns the block to RUN asynchronously. Pending state is discarded.
- rd=x0 never creates a hazard.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds outputs Stall_cnt, Flush_cnt, Wait_cnt (CNT_WIDTH each). All reset to 0. Each increments once per cycle in which, respectively:
  - a load-use stall is applied;
  - a branch flush is applied (including a pending flush);
  - the state is MEM_WAIT.
- Counters saturate at all-ones and freeze in HALT.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset_n low mid-MEM_WAIT at count 10 -> immediately all outputs 0, state RUN; Mem_ready not needed to recover.
- EX load to x5 with ID add reading rs2=x5 -> one cycle IF_Stall=ID_Stall=EX_Flush=1, then all 0. Same case with rd=x0 -> no stall.
- EX_Branch_taken=1 together with a load-use match -> ID_Flush=EX_Flush=1 for 1 cycle, IF_Stall=0.
- Mem_req=1, Mem_ready after 4 cycles, EX_Branch_taken pulsed in wait cycle 2 -> stalls for 5 cycles, then a single ID_Flush=EX_Flush=1 cycle.
- MEM_TIMEOUT=8, Mem_ready never asserted -> Halted=1 and Mem_timeout=1 after 8 wait cycles; outputs stay until reset. With HAZARD_PERF_CNT_EN, Wait_cnt=8.
- trap pulse for 1 cycle in RUN -> Halted=1 from the next cycle onward; all stall/flush outputs stay 1 after trap deasserts.
